// File: rtl/axi4_lite_read_slave_responder_pkg.sv
// Shared types, defaults and helpers for the AXI4-Lite read slave responder
// and its address FIFO.
package axi4_lite_read_slave_responder_pkg;

    localparam int DEFAULT_MAXLIMITOF_OUTSTANDINGTX = 10;
    localparam int DEFAULT_DELAY_WIDTH              = 5;

    // Same encoding the read master package uses on the R channel.
    typedef enum logic [1:0] {
        RRESP_OKAY   = 2'b00,
        RRESP_EXOKAY = 2'b01,
        RRESP_SLVERR = 2'b10,
        RRESP_DECERR = 2'b11
    } rresp_enum;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        RESP  = 2'b10
    } read_slave_state_enum;

    typedef enum logic [2:0] {
        DATA_SECURE_UNPRIV     = 3'b000,
        DATA_SECURE_PRIV       = 3'b001,
        DATA_NONSECURE_UNPRIV  = 3'b010,
        DATA_NONSECURE_PRIV    = 3'b011,
        INSTR_SECURE_UNPRIV    = 3'b100,
        INSTR_SECURE_PRIV      = 3'b101,
        INSTR_NONSECURE_UNPRIV = 3'b110,
        INSTR_NONSECURE_PRIV   = 3'b111
    } arprot_enum;

    localparam int ARPROT_PRIV_BIT = 0;

    function automatic logic is_privileged(input logic [2:0] prot);
        return prot[ARPROT_PRIV_BIT];
    endfunction

endpackage

// File: rtl/axi4_lite_read_slave_responder_addr_fifo.sv
// Synchronous first-word-fall-through FIFO holding accepted {araddr, arprot}
// entries; any depth, with occupancy count and full/empty flags.
module axi4_lite_read_addr_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 10,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_fire = push && !full;
    assign rd_fire = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge aclk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments keep every register update in this block order-independent.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_fire) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_read_slave_responder.sv
// AXI4-Lite read slave: queues AR requests, decodes them against a local
// register bank and returns one R beat each, in order, after a programmable delay.
module axi4_lite_read_slave_responder
    import axi4_lite_read_slave_responder_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH            = 32,
    parameter int                       DATA_WIDTH               = 32,
    parameter int                       DELAY_WIDTH              = DEFAULT_DELAY_WIDTH,
    parameter int                       MAXLIMITOF_OUTSTANDINGTX = DEFAULT_MAXLIMITOF_OUTSTANDINGTX,
    parameter int                       NUM_REGS                 = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR                = '0,
    parameter int                       PRIV_START               = 8
) (
    input  logic                                          aclk,
    input  logic                                          areset,
    input  logic [ADDRESS_WIDTH-1:0]                      araddr,
    input  logic [2:0]                                    arprot,
    input  logic                                          arvalid,
    output logic                                          arready,
    output logic [DATA_WIDTH-1:0]                         rdata,
    output logic [1:0]                                    rresp,
    output logic                                          rvalid,
    input  logic                                          rready,
    input  logic [DELAY_WIDTH-1:0]                        rvalid_delay,
    input  logic                                          mem_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]                   mem_wr_index,
    input  logic [DATA_WIDTH-1:0]                         mem_wr_data,
    output logic [$clog2(MAXLIMITOF_OUTSTANDINGTX+2)-1:0] outstanding_count
);

    localparam int                IDX_W    = $clog2(NUM_REGS);
    localparam int                FIFO_W   = ADDRESS_WIDTH + 3;
    localparam int                CNT_W    = $clog2(MAXLIMITOF_OUTSTANDINGTX + 1);
    localparam int                OUT_W    = $clog2(MAXLIMITOF_OUTSTANDINGTX + 2);
    localparam logic [IDX_W:0]    PRIV_IDX = (IDX_W + 1)'(PRIV_START);

    read_slave_state_enum     state;
    logic [DELAY_WIDTH-1:0]   delay_cnt;
    rresp_enum                rresp_q;
    logic [DATA_WIDTH-1:0]    bank [NUM_REGS];

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_W-1:0]        fifo_rd_data;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W-1:0]         next_fifo_count;

    logic [ADDRESS_WIDTH-1:0] pop_addr;
    logic [2:0]               pop_prot;
    logic [IDX_W-1:0]         pop_index;
    logic                     in_range;
    rresp_enum                dec_resp;
    logic [DATA_WIDTH-1:0]    dec_data;

    assign fifo_push = arvalid && arready && !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    axi4_lite_read_addr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (MAXLIMITOF_OUTSTANDINGTX)
    ) u_addr_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .push    (fifo_push),
        .wr_data ({araddr, arprot}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // arready looks one cycle ahead so it is already low when the last slot fills.
    assign next_fifo_count = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arready <= 1'b0;
        end else begin
            arready <= (next_fifo_count < CNT_W'(MAXLIMITOF_OUTSTANDINGTX));
        end
    end

    assign outstanding_count = OUT_W'(fifo_count) + OUT_W'(state != IDLE);

    // BASE_ADDR is aligned to the bank size, so the range test is a tag compare.
    assign {pop_addr, pop_prot} = fifo_rd_data;
    assign pop_index            = pop_addr[IDX_W+1:2];
    assign in_range             = (pop_addr[ADDRESS_WIDTH-1:IDX_W+2] == BASE_ADDR[ADDRESS_WIDTH-1:IDX_W+2]);

    // NOTE: defaults come first so every path assigns each output and no latch is inferred.
    always_comb begin
        dec_resp = RRESP_OKAY;
        if (!in_range) begin
            dec_resp = RRESP_DECERR;
        end else if (pop_addr[1:0] != 2'b00) begin
            dec_resp = RRESP_SLVERR;
        end else if (!is_privileged(pop_prot) && ({1'b0, pop_index} >= PRIV_IDX)) begin
            dec_resp = RRESP_SLVERR;
        end
        dec_data = (dec_resp == RRESP_OKAY) ? bank[pop_index] : '0;
    end

    // A pop in the same cycle as a backdoor write to that word reads the old value.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
        end else if (mem_wr_en) begin
            bank[mem_wr_index] <= mem_wr_data;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            delay_cnt <= '0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp_q   <= RRESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        rdata     <= dec_data;
                        rresp_q   <= dec_resp;
                        delay_cnt <= rvalid_delay;
                        if (rvalid_delay == '0) begin
                            state  <= RESP;
                            rvalid <= 1'b1;
                        end else begin
                            state <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    delay_cnt <= delay_cnt - DELAY_WIDTH'(1);
                    if (delay_cnt == DELAY_WIDTH'(1)) begin
                        state  <= RESP;
                        rvalid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign rresp = rresp_q;

endmodule

// File: tb/tb_axi4_lite_read_slave_responder.sv
// Scoreboard bench for axi4_lite_read_slave_responder: expected beats are
// queued at AR acceptance from an address-rule model and popped by an R monitor.
module tb_axi4_lite_read_slave_responder;

    localparam int     NUM_REGS   = 16;
    localparam longint BASE       = 0;
    localparam int     PRIV_START = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [4:0]  rvalid_delay;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_index;
    logic [31:0] mem_wr_data;
    logic [3:0]  outstanding_count;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    beat_t       exp_q [$];
    logic [31:0] model_bank [NUM_REGS];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          n_accepted = 0;
    bit          rready_random = 1'b0;

    axi4_lite_read_slave_responder dut (
        .aclk              (aclk),
        .areset            (areset),
        .araddr            (araddr),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rvalid            (rvalid),
        .rready            (rready),
        .rvalid_delay      (rvalid_delay),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_index      (mem_wr_index),
        .mem_wr_data       (mem_wr_data),
        .outstanding_count (outstanding_count)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Address rules applied directly to the byte address.
    function automatic beat_t model_read(input logic [31:0] addr, input logic [2:0] prot);
        beat_t  b;
        longint a;
        a      = longint'(addr);
        b.data = 32'h0;
        b.resp = 2'b00;
        if (a < BASE || a > BASE + 4 * NUM_REGS - 1) begin
            b.resp = 2'b11;
        end else if (a % 4 != 0) begin
            b.resp = 2'b10;
        end else if (prot[0] == 1'b0 && (a - BASE) / 4 >= PRIV_START) begin
            b.resp = 2'b10;
        end else begin
            b.data = model_bank[int'((a - BASE) / 4)];
        end
        return b;
    endfunction

    // Monitor: scores every R handshake and checks that a pending beat holds still.
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [1:0]  prev_resp  = '0;

    always @(negedge aclk) begin
        beat_t e;
        if (areset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("rvalid_held", rvalid, 1);
                check("rdata_stable", rdata, prev_data);
                check("rresp_stable", rresp, prev_resp);
            end
            if (rvalid && !prev_valid) begin
                rise_cyc = cyc;
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", rresp, e.resp);
                end
            end
            prev_valid = rvalid;
            prev_hs    = rvalid && rready;
            prev_data  = rdata;
            prev_resp  = rresp;
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rready_random) begin
                rready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called and returns one time unit after a rising edge.
    task automatic do_ar(input logic [31:0] addr, input logic [2:0] prot, output int hs_cyc);
        bit got;
        got     = 1'b0;
        hs_cyc  = -1;
        araddr  = addr;
        arprot  = prot;
        arvalid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge aclk);
            if (arready) begin
                got = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        if (got) begin
            @(posedge aclk);
            exp_q.push_back(model_read(addr, prot));
            n_accepted++;
            #1;
            hs_cyc  = cyc;
            arvalid = 1'b0;
        end else begin
            arvalid = 1'b0;
            check("ar_accept_timeout", 0, 1);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] data);
        mem_wr_en    = 1'b1;
        mem_wr_index = 4'(idx);
        mem_wr_data  = data;
        @(posedge aclk);
        #1;
        mem_wr_en       = 1'b0;
        model_bank[idx] = data;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 600; i++) begin
            @(posedge aclk);
            #1;
            if (exp_q.size() == 0 && outstanding_count == 0 && !rvalid) break;
        end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic wait_accepted(input int target);
        for (int i = 0; i < 200; i++) begin
            if (n_accepted >= target) break;
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        int hs;
        int acc0;
        logic [31:0] addr;
        logic [2:0]  prot;

        areset       = 1'b1;
        araddr       = '0;
        arprot       = '0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        rvalid_delay = '0;
        mem_wr_en    = 1'b0;
        mem_wr_index = '0;
        mem_wr_data  = '0;
        for (int i = 0; i < NUM_REGS; i++) model_bank[i] = '0;

        #12;
        check("reset_arready", arready, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_rdata", rdata, 0);
        check("reset_rresp", rresp, 0);
        check("reset_count", outstanding_count, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("arready_before_first_edge", arready, 0);
        @(posedge aclk);
        #1;
        check("arready_after_first_edge", arready, 1);

        for (int i = 0; i < NUM_REGS; i++) begin
            bd_write(i, (i == 3) ? 32'hDEAD_BEEF : $urandom());
        end

        // Single read, zero delay.
        rready = 1'b1;
        do_ar(32'h0000_000C, 3'b001, hs);
        wait_drain("single");
        check("single_latency", rise_cyc - hs + 1, 2);
        check("single_count_idle", outstanding_count, 0);

        // Decode rules and range edges.
        do_ar(32'h0000_0040, 3'b001, hs);
        do_ar(32'h0000_0006, 3'b001, hs);
        do_ar(32'h0000_0020, 3'b000, hs);
        do_ar(32'h0000_0020, 3'b001, hs);
        do_ar(32'h0000_001C, 3'b000, hs);
        do_ar(32'h0000_003C, 3'b001, hs);
        do_ar(32'hFFFF_FFFC, 3'b001, hs);
        wait_drain("errors");

        // Backdoor write on the pop edge: first read sees the old word.
        do_ar(32'h0000_0014, 3'b001, hs);
        bd_write(5, 32'hCAFE_0005);
        do_ar(32'h0000_0014, 3'b001, hs);
        wait_drain("same_cycle_write");

        // Backpressure until full.
        rready = 1'b0;
        acc0   = n_accepted;
        fork
            begin
                int h;
                for (int i = 0; i < 12; i++) do_ar(32'(i * 4), 3'b001, h);
            end
        join_none
        wait_accepted(acc0 + 11);
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        check("full_accepted", n_accepted - acc0, 11);
        check("full_arready_low", arready, 0);
        check("full_count", outstanding_count, 11);
        rready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("full_arready_at_pop", arready, 0);
        @(negedge aclk);
        check("full_arready_reopen", arready, 1);
        @(posedge aclk);
        #1;
        wait_accepted(acc0 + 12);
        wait fork;
        check("full_all_accepted", n_accepted - acc0, 12);
        wait_drain("full");

        // Long delay with rready held low.
        rready       = 1'b0;
        rvalid_delay = 5'd7;
        do_ar(32'h0000_000C, 3'b001, hs);
        for (int i = 0; i < 40; i++) begin
            if (rvalid) break;
            @(posedge aclk);
            #1;
        end
        repeat (5) begin
            @(posedge aclk);
            #1;
        end
        check("delay7_latency", rise_cyc - hs + 1, 9);
        check("hold_rvalid", rvalid, 1);
        check("hold_rdata", rdata, model_bank[3]);
        rready = 1'b1;
        wait_drain("delay");
        rvalid_delay = '0;

        // Reset with one beat presented and three queued.
        rready = 1'b0;
        do_ar(32'h0000_000C, 3'b001, hs);
        do_ar(32'h0000_0010, 3'b001, hs);
        do_ar(32'h0000_0014, 3'b001, hs);
        do_ar(32'h0000_0018, 3'b001, hs);
        check("rst_pre_count", outstanding_count, 4);
        check("rst_pre_rvalid", rvalid, 1);
        areset = 1'b1;
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_count", outstanding_count, 0);
        check("rst_rdata", rdata, 0);
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) model_bank[i] = '0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("rst_release_arready", arready, 0);
        @(posedge aclk);
        #1;
        check("rst_reopen_arready", arready, 1);
        rready = 1'b1;
        repeat (4) begin
            @(posedge aclk);
            #1;
        end
        check("rst_no_stale_beat", rvalid, 0);
        do_ar(32'h0000_000C, 3'b001, hs);
        wait_drain("post_reset");

        // Randomized traffic with random backpressure and delays.
        for (int i = 0; i < NUM_REGS; i++) bd_write(i, $urandom());
        rready_random = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (t % 15 == 14) begin
                rready_random = 1'b0;
                rready        = 1'b1;
                wait_drain("random_mid");
                bd_write($urandom_range(0, NUM_REGS - 1), $urandom());
                bd_write($urandom_range(0, NUM_REGS - 1), $urandom());
                rready_random = 1'b1;
            end
            case ($urandom_range(0, 9))
                0:       addr = $urandom() | 32'h0000_0100;
                1:       addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                default: addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            endcase
            prot         = 3'($urandom_range(0, 7));
            rvalid_delay = 5'($urandom_range(0, 3));
            do_ar(addr, prot, hs);
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
        end
        rready_random = 1'b0;
        rready        = 1'b1;
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_lite_read_slave_responder.md
Name: axi4_lite_read_slave_responder

Overview:
- Synthesizable AXI4-Lite read responder: the slave end of the read channels that the read master VIP drives.
- Accepts AR transactions into an outstanding-address FIFO and decodes each one against a local register bank.
- Returns R beats with OKAY/SLVERR/DECERR and a programmable RVALID delay.
- Serves as the DUT-side endpoint for master-VIP regressions and as a reusable register-read slave.

Parameters:
- ADDRESS_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width; fixed 32 (4-byte words).
- DELAY_WIDTH, 5, width of the rvalid_delay input.
- MAXLIMITOF_OUTSTANDINGTX, 10, AR FIFO depth (accepted but unanswered addresses).
- NUM_REGS, 16, words in the register bank; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*NUM_REGS.
- PRIV_START, 8, first word index that is privileged-only.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- areset  in  1  asynchronous, active-high reset.
- araddr  in  ADDRESS_WIDTH  read address.
- arprot  in  3  protection; bit0 = privileged.
- arvalid  in  1  address valid.
- arready  out  1  address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response, rrespEnum encoding.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rvalid_delay  in  DELAY_WIDTH  extra cycles before RVALID, sampled per transaction at pop.
- mem_wr_en  in  1  backdoor write strobe.
- mem_wr_index  in  $clog2(NUM_REGS)  backdoor word index.
- mem_wr_data  in  DATA_WIDTH  backdoor write data.
- outstanding_count  out  $clog2(MAXLIMITOF_OUTSTANDINGTX+2)  FIFO entries plus one if the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - arready=0, rvalid=0, rdata=0, rresp=OKAY(00), outstanding_count=0.
  - FIFO emptied, FSM to IDLE, all register-bank words cleared to 0.
  - arready rises on the first aclk edge after areset deasserts.
  - Reset mid-transaction discards all accepted and in-flight transactions; no R beat is issued for them.
- AR channel:
  - arready is registered: next arready = (next FIFO count < MAXLIMITOF_OUTSTANDINGTX).
  - A push occurs on arvalid && arready and stores {araddr, arprot}.
  - When full, arready=0. A pop in the same cycle frees a slot, and arready=1 from the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Decode, performed at pop; priority order:
  - Address outside [BASE_ADDR, BASE_ADDR+4*NUM_REGS-1] -> DECERR (11).
  - araddr[1:0] != 0 -> SLVERR (10).
  - arprot[0]==0 and index >= PRIV_START -> SLVERR.
  - Otherwise OKAY (00), rdata = bank[(araddr-BASE_ADDR)>>2].
  - Any non-OKAY response drives rdata=0.
  - EXOKAY is never returned.
- R FSM states: IDLE, DELAY, RESP.
  - IDLE: if the FIFO is non-empty, pop, decode, and latch rdata/rresp plus cnt=rvalid_delay. Go to RESP if cnt==0, else DELAY.
  - DELAY: cnt decrements each cycle; when cnt==1, go to RESP.
  - RESP: rvalid=1. rdata/rresp are held stable until rready. On rvalid && rready, rvalid drops the next cycle and the FSM goes to IDLE.
- Latency and throughput:
  - AR handshake at cycle N gives FIFO visible at N+1, pop at N+1, rvalid at N+2+rvalid_delay.
  - Back-to-back responses have a one-cycle IDLE bubble: at most one beat per 2 cycles.
- rvalid is never withdrawn before the handshake; rready may be low for any number of cycles.
- Responses are returned in AR acceptance order.
- Backdoor write: the bank word is updated at the edge where mem_wr_en=1. A pop in the same cycle to the same index returns the old value.

Decomposition:
- Axi4LiteReadSlaveGlobalPkg holds:
  - rrespEnum (same encoding as the master package).
  - readSlaveStateEnum {IDLE, DELAY, RESP}.
  - the arprotEnum import.
  - MAXLIMITOF_OUTSTANDINGTX and DELAY_WIDTH defaults.
- Sub-module axi4_lite_read_addr_fifo: parameterized synchronous FIFO (width ADDRESS_WIDTH+3, depth MAXLIMITOF_OUTSTANDINGTX) with count, full and empty outputs and an asynchronous active-high reset.

Test Plan:
- Single read, default parameters: preload word 3 = 32'hDEAD_BEEF; AR araddr=0x0C, arprot=001, delay=0, rready=1 -> rvalid 2 cycles after AR handshake, rdata=DEADBEEF, rresp=00, outstanding_count returns to 0.
- Error responses:
  - araddr=0x40 -> rresp=11, rdata=0.
  - araddr=0x06 -> rresp=10.
  - araddr=0x20, arprot=000 -> rresp=10.
  - araddr=0x20, arprot=001 -> 00.
- Backpressure/full: rready=0, issue 12 ARs back-to-back -> 11 accepted (10 in FIFO + 1 in RESP), arready=0 until the first R handshake; then arready=1 one cycle after the pop. All 12 R beats are returned in order with the correct data.
- Delay and hold: rvalid_delay=7 -> rvalid 9 cycles after the handshake. rready held low for 5 cycles -> rdata/rresp stable throughout, rvalid stays high.
- Reset mid-operation: assert areset with 3 outstanding and rvalid=1 -> rvalid=0 and arready=0 immediately, count=0, bank cleared. After release, a read of word 3 returns 0 with rresp=00.
